// File: rtl/md_io_pkg.sv
// md_io_pkg: register offsets, pin vector type and reset constants for the controller port.
package md_io_pkg;
    localparam logic [2:0] IO_DATA  = 3'd0;
    localparam logic [2:0] IO_CTRL  = 3'd1;
    localparam logic [2:0] IO_TXD   = 3'd2;
    localparam logic [2:0] IO_RXD   = 3'd3;
    localparam logic [2:0] IO_SCTRL = 3'd4;

    typedef logic [6:0] pins_t;

    localparam logic [7:0] DATA_RST  = 8'h00;
    localparam logic [7:0] CTRL_RST  = 8'h00;
    localparam logic [7:0] RXD_VAL   = 8'h00;
    localparam pins_t      PIN_Q_RST = 7'h7F;
endpackage

// File: rtl/md_io_port.sv
// md_io_port: one console controller port with CPU registers, pin drive/sample and TH interrupt.
module md_io_port
    import md_io_pkg::*;
#(
    parameter logic       PULLUP    = 1'b1,
    parameter logic [7:0] SCTRL_RST = 8'h00,
    parameter logic [7:0] TXD_RST   = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_sel,
    input  logic [2:0] cpu_addr,
    input  logic       cpu_we,
    input  logic [7:0] cpu_din,
    output logic [7:0] cpu_dout,
    input  logic [6:0] pin_in,
    output logic [6:0] pin_out,
    output logic [6:0] pin_dir,
    output logic       th_int
);
    logic [7:0] data;
    logic [7:0] ctrl;
    logic [7:0] txd;
    logic [4:0] sctrl_hi;
    pins_t      pin_q;
    pins_t      eff;
    logic       th_prev;
    logic       wr;

    assign wr      = cpu_sel & cpu_we;
    assign pin_dir = ctrl[6:0];
    assign pin_out = (ctrl[6:0] & data[6:0]) | (~ctrl[6:0] & {7{PULLUP}});
    assign eff     = (ctrl[6:0] & data[6:0]) | (~ctrl[6:0] & pin_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            data     <= DATA_RST;
            ctrl     <= CTRL_RST;
            txd      <= TXD_RST;
            sctrl_hi <= SCTRL_RST[7:3];
            pin_q    <= PIN_Q_RST;
            th_prev  <= 1'b1;
            th_int   <= 1'b0;
        end else begin
            if (wr && cpu_addr == IO_DATA)  data     <= cpu_din;
            if (wr && cpu_addr == IO_CTRL)  ctrl     <= cpu_din;
            if (wr && cpu_addr == IO_TXD)   txd      <= cpu_din;
            if (wr && cpu_addr == IO_SCTRL) sctrl_hi <= cpu_din[7:3];
            pin_q   <= pin_in;
            th_prev <= eff[6];
            // Edge is judged on the effective TH level, so a direction flip that drops TH also counts.
            th_int  <= ctrl[7] & ~ctrl[6] & th_prev & ~eff[6];
        end
    end

    always_comb begin
        cpu_dout = 8'hFF;
        case (cpu_addr)
            IO_DATA:  cpu_dout = {data[7], eff};
            IO_CTRL:  cpu_dout = ctrl;
            IO_TXD:   cpu_dout = txd;
            IO_RXD:   cpu_dout = RXD_VAL;
            IO_SCTRL: cpu_dout = {sctrl_hi, 3'b000};
            default:  cpu_dout = 8'hFF;
        endcase
    end
endmodule

// File: tb/tb_md_io_port.sv
// tb_md_io_port: directed-vector bench for md_io_port with immediate-assertion checks.
module tb_md_io_port;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cpu_sel = 1'b0;
    logic [2:0] cpu_addr = 3'd0;
    logic       cpu_we = 1'b0;
    logic [7:0] cpu_din = 8'h00;
    logic [7:0] cpu_dout;
    logic [6:0] pin_in = 7'h2A;
    logic [6:0] pin_out;
    logic [6:0] pin_dir;
    logic       th_int;
    int         n_cmp = 0;
    int         n_bad = 0;

    md_io_port dut (
        .clk(clk), .reset(reset), .cpu_sel(cpu_sel), .cpu_addr(cpu_addr),
        .cpu_we(cpu_we), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
        .pin_in(pin_in), .pin_out(pin_out), .pin_dir(pin_dir), .th_int(th_int)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string tag);
        cpu_addr = a;
        #1;
        chk(tag, cpu_dout, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cpu_we = 1'b1;
        cpu_addr = a;
        cpu_din = d;
        tick();
        cpu_we = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        cpu_sel = 1'b1;
        chk("rst_dir", {1'b0, pin_dir}, 8'h00);
        chk("rst_out", {1'b0, pin_out}, 8'h7F);
        chk("rst_int", {7'b0, th_int}, 8'h00);
        rd(3'd0, 8'h7F, "rst_data");
        rd(3'd1, 8'h00, "rst_ctrl");
        rd(3'd2, 8'hFF, "rst_txd");
        rd(3'd3, 8'h00, "rst_rxd");
        rd(3'd4, 8'h00, "rst_sctrl");
        rd(3'd6, 8'hFF, "rst_unused");
        reset = 1'b0;
        tick();
        rd(3'd0, 8'h2A, "data_sampled");
        // Drive TH as output, then toggle it
        wr(3'd1, 8'h40);
        wr(3'd0, 8'h40);
        chk("dir_40", {1'b0, pin_dir}, 8'h40);
        chk("out_7f", {1'b0, pin_out}, 8'h7F);
        wr(3'd0, 8'h00);
        chk("out_3f", {1'b0, pin_out}, 8'h3F);
        pin_in = 7'h15;
        tick();
        rd(3'd0, 8'h15, "data_15");
        wr(3'd0, 8'h80);
        rd(3'd0, 8'h95, "data_bit7");
        // Plain TH falling edge on an input pin
        wr(3'd1, 8'h80);
        pin_in = 7'h7F;
        tick();
        tick();
        chk("th_idle", {7'b0, th_int}, 8'h00);
        pin_in = 7'h3F;
        tick();
        chk("th_e1", {7'b0, th_int}, 8'h00);
        tick();
        chk("th_pulse", {7'b0, th_int}, 8'h01);
        tick();
        chk("th_end", {7'b0, th_int}, 8'h00);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("th_held", {7'b0, th_int}, 8'h00);
        end
        // Direction change drops TH while interrupt enabled
        wr(3'd0, 8'h40);
        wr(3'd1, 8'hC0);
        tick();
        tick();
        chk("dir_drv", {7'b0, th_int}, 8'h00);
        wr(3'd1, 8'h80);
        chk("dir_wr", {7'b0, th_int}, 8'h00);
        tick();
        chk("dir_pulse", {7'b0, th_int}, 8'h01);
        tick();
        chk("dir_end", {7'b0, th_int}, 8'h00);
        // Same with interrupt disabled
        wr(3'd1, 8'h40);
        tick();
        tick();
        wr(3'd1, 8'h00);
        chk("dis_a", {7'b0, th_int}, 8'h00);
        tick();
        chk("dis_b", {7'b0, th_int}, 8'h00);
        // Enable in the same cycle the edge is sampled: fires
        pin_in = 7'h7F;
        tick();
        tick();
        pin_in = 7'h3F;
        wr(3'd1, 8'h80);
        tick();
        chk("en_same", {7'b0, th_int}, 8'h01);
        // Enable one cycle late: no pulse
        wr(3'd1, 8'h00);
        pin_in = 7'h7F;
        tick();
        tick();
        pin_in = 7'h3F;
        tick();
        wr(3'd1, 8'h80);
        chk("en_late_a", {7'b0, th_int}, 8'h00);
        tick();
        chk("en_late_b", {7'b0, th_int}, 8'h00);
        // Register odds and ends
        wr(3'd4, 8'hFF);
        rd(3'd4, 8'hF8, "sctrl_f8");
        wr(3'd3, 8'h55);
        rd(3'd3, 8'h00, "rxd_ro");
        wr(3'd5, 8'h12);
        rd(3'd5, 8'hFF, "unused_5");
        wr(3'd2, 8'h5A);
        rd(3'd2, 8'h5A, "txd_5a");
        cpu_sel = 1'b0;
        wr(3'd2, 8'h00);
        cpu_sel = 1'b1;
        rd(3'd2, 8'h5A, "txd_nosel");
        // Pending interrupt and a simultaneous write are both dropped by reset
        pin_in = 7'h7F;
        tick();
        tick();
        pin_in = 7'h3F;
        tick();
        reset = 1'b1;
        wr(3'd0, 8'h7F);
        reset = 1'b0;
        chk("rst_drop_int", {7'b0, th_int}, 8'h00);
        rd(3'd0, 8'h7F, "rst_wr_data");
        rd(3'd1, 8'h00, "rst_wr_ctrl");
        rd(3'd2, 8'hFF, "rst_wr_txd");
        rd(3'd4, 8'h00, "rst_wr_sctrl");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
